// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready load-store stream into pipelined
// single-word AHB-Lite transfers, with wait-state and error-retry handling.
module ahb_lite_master (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [31:0] HADDR,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   logic        r_aValid;
   logic        r_aWrite;
   logic [31:0] r_aAddr;
   logic [31:0] r_aWdata;
   logic        r_aSup;
   logic        r_dValid;
   logic        r_dWrite;
   logic [31:0] r_dWdata;
   logic        r_respValid;
   logic        r_respErr;
   logic [31:0] r_respRdata;

   logic w_err1;
   logic w_reqReady;
   logic w_accept;
   logic w_advance;
   logic w_complete;
   logic w_retry;

   // err1 is the first cycle of a two-cycle error; w_retry is its second cycle
   assign w_err1     = r_dValid & HRESP & ~HREADY;
   assign w_retry    = r_aSup & HREADY;
   assign w_advance  = HREADY & ~r_aSup;
   assign w_reqReady = ~w_err1 & ~r_aSup & (~r_aValid | HREADY);
   assign w_accept   = req_valid & w_reqReady;
   assign w_complete = r_dValid & HREADY;

   assign req_ready  = w_reqReady;
   assign HTRANS     = (r_aValid & ~r_aSup) ? TRANS_NONSEQ : TRANS_IDLE;
   assign HADDR      = r_aAddr;
   assign HWRITE     = r_aWrite;
   assign HWDATA     = r_dWdata;
   assign resp_valid = r_respValid;
   assign resp_err   = r_respErr;
   assign resp_rdata = r_respRdata;

   // Address phase: loads a new request whenever the slot frees up; otherwise
   // holds, which also keeps a suppressed transfer ready for re-issue.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_aValid <= 1'b0;
         r_aWrite <= 1'b0;
         r_aAddr  <= '0;
         r_aWdata <= '0;
      end else if (w_accept) begin
         r_aValid <= 1'b1;
         r_aWrite <= req_write;
         r_aAddr  <= {req_addr[31:2], 2'b00};
         r_aWdata <= req_wdata;
      end else if (w_advance) begin
         r_aValid <= 1'b0;
      end
   end

   // Data phase and error suppression
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_dValid <= 1'b0;
         r_dWrite <= 1'b0;
         r_dWdata <= '0;
         r_aSup   <= 1'b0;
      end else if (w_retry) begin
         r_dValid <= 1'b0;
         r_aSup   <= 1'b0;
      end else begin
         if (w_advance) begin
            r_dValid <= r_aValid;
            r_dWrite <= r_aWrite;
            r_dWdata <= r_aWdata;
         end
         if (w_err1) begin
            r_aSup <= r_aValid;
         end
      end
   end

   // Single-cycle response pulse on data-phase completion
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_respValid <= 1'b0;
         r_respErr   <= 1'b0;
         r_respRdata <= '0;
      end else begin
         r_respValid <= w_complete;
         r_respErr   <= w_complete & HRESP;
         r_respRdata <= (w_complete & ~r_dWrite & ~HRESP) ? HRDATA : '0;
      end
   end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Testbench for ahb_lite_master: AHB slave model with wait/error injection
// and an in-order response scoreboard.
module tb_ahb_lite_master;

   localparam logic [1:0]  NONSEQ   = 2'b10;
   localparam logic [1:0]  IDLE     = 2'b00;
   localparam logic [31:0] UNMAPPED = 32'hFFFF_0000;

   logic        HCLK;
   logic        HRESET;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   ahb_lite_master dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .HTRANS     (HTRANS),
      .HWRITE     (HWRITE),
      .HADDR      (HADDR),
      .HWDATA     (HWDATA),
      .HRDATA     (HRDATA),
      .HREADY     (HREADY),
      .HRESP      (HRESP)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Slave configuration, written only by the main stimulus process
   int          cfgWaitN;
   logic [31:0] cfgWaitAddr;
   logic        cfgErrEn;
   logic [31:0] cfgErrAddr;

   logic        sValid;
   logic        sWrite;
   logic [31:0] sAddr;
   int          sWait;
   logic [1:0]  sErrMode;
   logic        sErrStage;
   logic [31:0] slaveMem [0:255];
   logic [255:0] slaveWritten;

   function automatic logic [31:0] defaultWord(input logic [31:0] a);
      return 32'hC0DE_0000 | a;
   endfunction

   // Slave response for the current data phase
   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = 32'hDEAD_BEEF;
      if (sValid) begin
         if (sWait > 0) begin
            HREADY = 1'b0;
         end else if (sErrMode == 2'd2) begin
            HRESP = 1'b1;
         end else if (sErrMode == 2'd1) begin
            HRESP  = 1'b1;
            HREADY = sErrStage;
         end else if (!sWrite) begin
            HRDATA = slaveWritten[sAddr[9:2]] ? slaveMem[sAddr[9:2]] : defaultWord(sAddr);
         end
      end
   end

   // Slave pipeline: captures the address phase on HREADY, then counts waits
   always @(posedge HCLK) begin
      if (HRESET) begin
         sValid       <= 1'b0;
         sWrite       <= 1'b0;
         sAddr        <= '0;
         sWait        <= 0;
         sErrMode     <= 2'd0;
         sErrStage    <= 1'b0;
         slaveWritten <= '0;
      end else if (!HREADY) begin
         if (sWait > 0) sWait <= sWait - 1;
         else if (sErrMode == 2'd1) sErrStage <= 1'b1;
      end else begin
         if (sValid && sWrite && !HRESP) begin
            slaveMem[sAddr[9:2]]     <= HWDATA;
            slaveWritten[sAddr[9:2]] <= 1'b1;
         end
         sErrStage <= 1'b0;
         if (HTRANS == NONSEQ) begin
            sValid   <= 1'b1;
            sAddr    <= HADDR;
            sWrite   <= HWRITE;
            sWait    <= (cfgWaitN > 0 && HADDR == cfgWaitAddr) ? cfgWaitN : 0;
            sErrMode <= (HADDR == UNMAPPED) ? 2'd2 :
                        (cfgErrEn && HADDR == cfgErrAddr) ? 2'd1 : 2'd0;
         end else begin
            sValid <= 1'b0;
         end
      end
   end

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        expQ[$];
   int          respCycles[$];
   logic [31:0] refMem [logic [31:0]];
   int          testsRun;
   int          testsFailed;
   int          cycleNo;
   int          lastAcceptCycle;
   logic        lastAccept;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic pushExpected(input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t        e;
      logic [31:0] wa;
      wa      = {a[31:2], 2'b00};
      e.err   = 1'b0;
      e.rdata = '0;
      if (wa == UNMAPPED || (cfgErrEn && wa == cfgErrAddr)) e.err = 1'b1;
      else if (w) refMem[wa] = d;
      else e.rdata = refMem.exists(wa) ? refMem[wa] : defaultWord(wa);
      expQ.push_back(e);
   endtask

   // One bus cycle: score any response, then drive the request for the next edge
   task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      @(negedge HCLK);
      cycleNo++;
      if (!HRESET && resp_valid === 1'b1) begin
         respCycles.push_back(cycleNo);
         if (expQ.size() == 0) begin
            checkOutput("respExpected", 32'(resp_valid), 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("respErr", 32'(resp_err), 32'(e.err));
            checkOutput("respRdata", resp_rdata, e.rdata);
         end
      end
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      #1;
      lastAccept = v && !HRESET && (req_ready === 1'b1);
      if (lastAccept) begin
         lastAcceptCycle = cycleNo;
         pushExpected(w, a, d);
      end
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
      lastAccept = 1'b0;
      for (int n = 0; n < 50 && !lastAccept; n++) applyStimulus(1'b1, w, a, d);
      if (!lastAccept) checkOutput("acceptTimeout", 32'(lastAccept), 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40 && expQ.size() != 0; i++) idle(1);
      idle(2);
      checkOutput(tag, 32'(expQ.size()), 32'd0);
   endtask

   int t0;

   initial begin
      HRESET      = 1'b1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      cfgWaitN    = 0;
      cfgWaitAddr = '0;
      cfgErrEn    = 1'b0;
      cfgErrAddr  = '0;
      testsRun    = 0;
      testsFailed = 0;
      cycleNo     = 0;
      lastAccept  = 1'b0;
      lastAcceptCycle = 0;
      t0 = 0;

      // Reset state
      idle(2);
      checkOutput("rstHtrans", 32'(HTRANS), 32'(IDLE));
      checkOutput("rstHaddr", HADDR, 32'd0);
      checkOutput("rstHwrite", 32'(HWRITE), 32'd0);
      checkOutput("rstHwdata", HWDATA, 32'd0);
      checkOutput("rstRespValid", 32'(resp_valid), 32'd0);
      checkOutput("rstRespErr", 32'(resp_err), 32'd0);
      checkOutput("rstRespRdata", resp_rdata, 32'd0);
      checkOutput("rstReqReady", 32'(req_ready), 32'd1);
      HRESET = 1'b0;

      // Store then load to the same word
      respCycles.delete();
      issue(1'b1, 32'h0000_0104, 32'h0000_00A5);
      t0 = lastAcceptCycle;
      issue(1'b0, 32'h0000_0104, 32'd0);
      checkOutput("t1StoreHtrans", 32'(HTRANS), 32'(NONSEQ));
      checkOutput("t1StoreHaddr", HADDR, 32'h0000_0104);
      checkOutput("t1StoreHwrite", 32'(HWRITE), 32'd1);
      idle(1);
      checkOutput("t1LoadHtrans", 32'(HTRANS), 32'(NONSEQ));
      checkOutput("t1LoadHaddr", HADDR, 32'h0000_0104);
      checkOutput("t1LoadHwrite", 32'(HWRITE), 32'd0);
      checkOutput("t1Hwdata", HWDATA, 32'h0000_00A5);
      drain("t1Drain");
      checkOutput("t1RespCount", 32'(respCycles.size()), 32'd2);
      checkOutput("t1Latency", 32'(respCycles[0]), 32'(t0 + 3));
      checkOutput("t1SecondResp", 32'(respCycles[1]), 32'(t0 + 4));

      // Four back-to-back loads
      respCycles.delete();
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            applyStimulus(1'b1, 1'b0, 32'(i * 4), 32'd0);
            checkOutput("t2Accept", 32'(lastAccept), 32'd1);
         end else begin
            idle(1);
         end
         if (i >= 1) begin
            checkOutput("t2Htrans", 32'(HTRANS), 32'(NONSEQ));
            checkOutput("t2Haddr", HADDR, 32'((i - 1) * 4));
         end
      end
      drain("t2Drain");
      checkOutput("t2RespCount", 32'(respCycles.size()), 32'd4);
      for (int i = 0; i < 3; i++)
         checkOutput("t2Consecutive", 32'(respCycles[i + 1]), 32'(respCycles[i] + 1));

      // Three wait states on a load with a second request queued
      cfgWaitAddr = 32'h0000_0020;
      cfgWaitN    = 3;
      respCycles.delete();
      issue(1'b0, 32'h0000_0020, 32'd0);
      t0 = lastAcceptCycle;
      issue(1'b0, 32'h0000_0024, 32'd0);
      for (int j = 0; j < 3; j++) begin
         applyStimulus(1'b1, 1'b0, 32'h0000_0028, 32'd0);
         checkOutput("t3ReqReady", 32'(req_ready), 32'd0);
         checkOutput("t3Htrans", 32'(HTRANS), 32'(NONSEQ));
         checkOutput("t3Haddr", HADDR, 32'h0000_0024);
         if (lastAccept) break;
      end
      if (!lastAccept) issue(1'b0, 32'h0000_0028, 32'd0);
      drain("t3Drain");
      cfgWaitN = 0;
      checkOutput("t3RespCount", 32'(respCycles.size()), 32'd3);
      checkOutput("t3WaitLatency", 32'(respCycles[0]), 32'(t0 + 6));
      checkOutput("t3SecondResp", 32'(respCycles[1]), 32'(t0 + 7));

      // Two-cycle error on a store with a load queued behind it
      cfgErrAddr = 32'h0000_0040;
      cfgErrEn   = 1'b1;
      respCycles.delete();
      issue(1'b1, 32'h0000_0040, 32'h1234_5678);
      issue(1'b0, 32'h0000_0008, 32'd0);
      idle(1);
      checkOutput("t4Err1ReqReady", 32'(req_ready), 32'd0);
      checkOutput("t4Err1Htrans", 32'(HTRANS), 32'(NONSEQ));
      idle(1);
      checkOutput("t4Err2Htrans", 32'(HTRANS), 32'(IDLE));
      checkOutput("t4Err2ReqReady", 32'(req_ready), 32'd0);
      idle(1);
      checkOutput("t4ReissueHtrans", 32'(HTRANS), 32'(NONSEQ));
      checkOutput("t4ReissueHaddr", HADDR, 32'h0000_0008);
      drain("t4Drain");
      cfgErrEn = 1'b0;
      checkOutput("t4RespCount", 32'(respCycles.size()), 32'd2);

      // Unmapped address with a single-cycle error
      respCycles.delete();
      issue(1'b0, UNMAPPED, 32'd0);
      issue(1'b0, 32'h0000_0010, 32'd0);
      drain("t5Drain");
      checkOutput("t5RespCount", 32'(respCycles.size()), 32'd2);

      // Reset during a wait-stated data phase
      cfgWaitAddr = 32'h0000_0030;
      cfgWaitN    = 5;
      issue(1'b0, 32'h0000_0030, 32'd0);
      idle(2);
      HRESET = 1'b1;
      idle(1);
      checkOutput("t6Htrans", 32'(HTRANS), 32'(IDLE));
      checkOutput("t6Haddr", HADDR, 32'd0);
      checkOutput("t6RespValid", 32'(resp_valid), 32'd0);
      checkOutput("t6ReqReady", 32'(req_ready), 32'd1);
      HRESET = 1'b0;
      expQ.delete();
      refMem.delete();
      cfgWaitN = 0;
      respCycles.delete();
      idle(3);
      checkOutput("t6NoResp", 32'(respCycles.size()), 32'd0);
      issue(1'b0, 32'h0000_000C, 32'd0);
      drain("t6Drain");
      checkOutput("t6RespCount", 32'(respCycles.size()), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- AHB-Lite initiator that turns the CPU core's valid/ready load-store request stream into pipelined single-word AHB-Lite transfers.
- It drives the interconnect matrix's bus side (HWRITE, HTRANS, HADDR, HWDATA) and consumes its HRDATA, HREADY and HRESP.
- One address phase and one data phase can be in flight at once, so back-to-back transfers overlap.
- Wait states and the two-cycle error response are handled; a transfer cancelled by an error is re-issued automatically.

Parameters:
- None. Bus is fixed at 32-bit word transfers; no HSIZE or HBURST are generated.

Ports:
- HCLK  input  1  bus clock; all state changes on its rising edge.
- HRESET  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  request accepted at this edge when req_valid=1.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_wdata  input  32  store data.
- resp_valid  output  1  one-cycle pulse: transfer finished.
- resp_rdata  output  32  load data; 0 for stores.
- resp_err  output  1  the finished transfer got HRESP=1.
- HTRANS  output  2  2'b10 NONSEQ or 2'b00 IDLE only.
- HWRITE  output  1  address-phase direction.
- HADDR  output  32  address-phase address, {req_addr[31:2],2'b00}.
- HWDATA  output  32  data-phase write data.
- HRDATA  input  32  read data from the matrix.
- HREADY  input  1  data phase completes at this edge.
- HRESP  input  1  error response.

Behaviour:
- All AHB outputs come straight from registers.
- Address-phase register A: a_valid, a_write, a_addr, a_wdata, a_sup.
- Data-phase register D: d_valid, d_write, d_wdata.
- HTRANS = (a_valid & ~a_sup) ? NONSEQ : IDLE. HADDR and HWRITE come from A. HWDATA = d_wdata.
- err1 = d_valid & HRESP & ~HREADY (first cycle of an error response).
- req_ready = ~err1 & ~a_sup & (~a_valid | HREADY) — combinational.
- Normal edge with HREADY=1 and no suppression:
  - D <= A (d_valid = a_valid).
  - A <= accepted request, or a_valid <= 0 if none accepted.
- Edge with HREADY=0:
  - D is held.
  - If ~a_valid, A may still load an accepted request.
  - A is otherwise held; HADDR, HWRITE and HTRANS stay stable during wait states.
- Edge with err1:
  - a_sup <= a_valid, so HTRANS is IDLE in the second error cycle.
  - A content is kept.
- Edge with a_sup=1 and HREADY=1:
  - d_valid <= 0; a_sup <= 0.
  - A is re-issued from the next cycle; the cancelled request is never reported as an error.
- Completion: d_valid & HREADY at an edge sets the following for exactly one cycle:
  - resp_valid <= 1.
  - resp_err <= HRESP.
  - resp_rdata <= (~d_write & ~HRESP) ? HRDATA : 0.
- Single-cycle error (HRESP=1 with HREADY=1) is a completion with resp_err=1; no suppression.
- HRESP and HRDATA are ignored whenever d_valid=0.
- Latency with no wait states, request accepted at edge N:
  - HTRANS=NONSEQ in cycle N+1.
  - Data phase in cycle N+2.
  - resp_valid high in cycle N+3.
- Throughput: one transfer per cycle when req_valid stays high and HREADY=1.
- Responses come back in request order.
- Reset (synchronous, may hit mid-transfer):
  - A, D and a_sup are cleared; HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - In-flight transfers are dropped with no response.
  - req_ready reads 1 while no error is pending.

Test Plan:
- Reset, then store 0x0000_00A5 to 0x0000_0104, then load 0x0000_0104 to the RAM model with HREADY=1 -> HADDR=0x104 with HTRANS=NONSEQ on consecutive cycles; HWDATA=0xA5 in the store's data phase; second resp_valid carries resp_rdata=0xA5, resp_err=0.
- 4 back-to-back loads from 0x00..0x0C -> HTRANS=NONSEQ for 4 consecutive cycles; 4 resp_valid pulses on consecutive cycles, in order.
- Slave inserts 3 wait states (HREADY=0) on a load with a second request queued -> HADDR/HTRANS frozen; req_ready=0 for those 3 cycles; response arrives 3 cycles late; second transfer unaffected.
- Two-cycle error on a store with a load to 0x8 pending in A -> HTRANS=IDLE in the second error cycle; resp_err=1 for the store only; load re-issued with NONSEQ and completes resp_err=0.
- Unmapped address 0xFFFF_0000 where the matrix returns HRESP=1, HREADY=1 -> one resp_valid with resp_err=1, resp_rdata=0; next request proceeds.
- HRESET asserted during a wait-stated data phase -> next cycle HTRANS=IDLE, HADDR=0, no resp_valid; a following load completes normally.
